// File: rtl/pc_trace_ctl_pkg.sv
// Shared types for the PC trace controller: FSM state encoding, PC type and
// the default post-trigger capture length.
package pc_trace_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

  typedef logic [17:0] pc_t;

  localparam int POST_LEN_DEFAULT = 16;

endpackage

// File: rtl/pc_trace_ctl.sv
// Feeds the PC-history LIFO from the fetch stream (deduped, trigger + post count)
// and pops it one entry per console read strobe, newest PC first.
module pc_trace_ctl
  import pc_trace_ctl_pkg::*;
#(
  parameter int PC_WIDTH  = 18,
  parameter int POST_LEN  = POST_LEN_DEFAULT,
  parameter int CNT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clken,
  input  logic                cpu_fetch,
  input  logic [PC_WIDTH-1:0] cpu_pc,
  input  logic                ctl_arm,
  input  logic                ctl_disarm,
  input  logic                ctl_clr,
  input  logic                ctl_match_en,
  input  logic [PC_WIDTH-1:0] ctl_match_addr,
  input  logic                rd_req,
  output logic [PC_WIDTH-1:0] rd_data,
  output logic                rd_valid,
  output logic                rd_nak,
  output logic [1:0]          stat_state,
  output logic                stat_trig,
  output logic                stat_wrap,
  output logic                lifo_clr,
  output logic                lifo_push,
  output logic                lifo_pop,
  output logic [PC_WIDTH-1:0] lifo_in,
  input  logic [PC_WIDTH-1:0] lifo_out,
  input  logic                lifo_full,
  input  logic                lifo_empty
);

  trace_state_t         state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [PC_WIDTH-1:0]  last_pc;
  logic                 last_pc_vld;
  logic                 capturing;
  logic                 fe;
  logic                 hit;
  logic                 push;
  logic                 pop;
  logic                 flags_clr;
  logic                 trig_set;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    flags_clr = 1'b0;
    trig_set  = 1'b0;
    lifo_clr  = rst;
    capturing = (state == ARMED) || (state == POST);
    // A clear or disarm cycle never pushes, even with a fetch present.
    fe   = clken & cpu_fetch & capturing & ~ctl_clr & ~ctl_disarm & ~rst;
    hit  = fe & (state == ARMED) & ctl_match_en & (cpu_pc == ctl_match_addr);
    push = fe & (hit | ~last_pc_vld | (cpu_pc != last_pc));
    pop  = rd_req & ~capturing & ~lifo_empty & ~rst;

    if (ctl_clr) begin
      state_nxt = IDLE;
      lifo_clr  = 1'b1;
      flags_clr = 1'b1;
    end else if (ctl_disarm && capturing) begin
      state_nxt = DONE;
    end else if (ctl_arm && !capturing) begin
      state_nxt = ARMED;
      lifo_clr  = 1'b1;
      flags_clr = 1'b1;
    end else if (hit) begin
      trig_set  = 1'b1;
      cnt_nxt   = CNT_WIDTH'(POST_LEN);
      state_nxt = (POST_LEN == 0) ? DONE : POST;
    end else if (push && (state == POST)) begin
      cnt_nxt = cnt - CNT_WIDTH'(1);
      if (cnt == CNT_WIDTH'(1)) state_nxt = DONE;
    end
  end

  assign lifo_push  = push;
  assign lifo_pop   = pop;
  assign lifo_in    = push ? cpu_pc : '0;
  assign stat_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_pc     <= '0;
      last_pc_vld <= 1'b0;
      stat_trig   <= 1'b0;
      stat_wrap   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (flags_clr) begin
        stat_trig   <= 1'b0;
        stat_wrap   <= 1'b0;
        last_pc_vld <= 1'b0;
      end else begin
        if (trig_set) stat_trig <= 1'b1;
        if (push) begin
          last_pc     <= cpu_pc;
          last_pc_vld <= 1'b1;
          if (lifo_full) stat_wrap <= 1'b1;
        end
      end
    end
  end

  // Read handshake: every rd_req cycle gets rd_valid exactly one cycle later;
  // rd_nak alongside it means no data (empty stack or capture in progress).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_nak   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_nak   <= rd_req & ~pop;
      if (pop) rd_data <= lifo_out;
      else if (rd_req) rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_pc_trace_ctl.sv
// Bench for pc_trace_ctl: behavioural 64-deep LIFO stand-in, a rule-level
// reference model of the controller, directed scenarios and random traffic.
module tb_pc_trace_ctl;

  localparam int W     = 18;
  localparam int PL    = 6;
  localparam int DEPTH = 64;

  logic         clk = 1'b0;
  logic         rst, clken, cpu_fetch, ctl_arm, ctl_disarm, ctl_clr, ctl_match_en, rd_req;
  logic [W-1:0] cpu_pc, ctl_match_addr;
  logic [W-1:0] rd_data, lifo_in;
  logic         rd_valid, rd_nak, stat_trig, stat_wrap, lifo_clr, lifo_push, lifo_pop;
  logic [1:0]   stat_state;
  logic [W-1:0] lifo_out   = '0;
  logic         lifo_full  = 1'b0;
  logic         lifo_empty = 1'b1;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pc_trace_ctl #(.PC_WIDTH(W), .POST_LEN(PL), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clken(clken), .cpu_fetch(cpu_fetch), .cpu_pc(cpu_pc),
    .ctl_arm(ctl_arm), .ctl_disarm(ctl_disarm), .ctl_clr(ctl_clr),
    .ctl_match_en(ctl_match_en), .ctl_match_addr(ctl_match_addr),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .rd_nak(rd_nak),
    .stat_state(stat_state), .stat_trig(stat_trig), .stat_wrap(stat_wrap),
    .lifo_clr(lifo_clr), .lifo_push(lifo_push), .lifo_pop(lifo_pop), .lifo_in(lifo_in),
    .lifo_out(lifo_out), .lifo_full(lifo_full), .lifo_empty(lifo_empty)
  );

  // LIFO stand-in: overwrites its oldest entry when pushed while full.
  logic [W-1:0] lifo_q[$];
  always @(posedge clk) begin
    if (lifo_clr) lifo_q.delete();
    else if (lifo_push) begin
      if (lifo_q.size() == DEPTH) void'(lifo_q.pop_front());
      lifo_q.push_back(lifo_in);
    end else if (lifo_pop && lifo_q.size() > 0) void'(lifo_q.pop_back());
    lifo_out   <= (lifo_q.size() > 0) ? lifo_q[lifo_q.size()-1] : '0;
    lifo_full  <= (lifo_q.size() == DEPTH);
    lifo_empty <= (lifo_q.size() == 0);
  end

  // Reference model: 0 idle, 1 armed, 2 post, 3 done.
  int           m_state = 0;
  bit           m_have  = 1'b0;
  logic [W-1:0] m_last  = '0;
  int           m_left  = 0;
  bit           m_trig  = 1'b0;
  bit           m_wrap  = 1'b0;
  bit           m_valid = 1'b0;
  bit           m_nak   = 1'b0;
  logic [W-1:0] m_data  = '0;
  logic [W-1:0] exp_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(output bit e_push, output bit e_pop, output bit e_clr,
                            output logic [W-1:0] e_in);
    bit quiet;
    bit hit;
    e_push = 1'b0; e_pop = 1'b0; e_clr = 1'b0; e_in = '0;
    if (rst) begin
      e_clr = 1'b1; m_state = 0; m_have = 1'b0; m_last = '0; m_left = 0;
      m_trig = 1'b0; m_wrap = 1'b0; m_valid = 1'b0; m_nak = 1'b0; m_data = '0;
      exp_q.delete();
      return;
    end
    quiet   = (m_state == 0) || (m_state == 3);
    m_valid = rd_req;
    m_nak   = 1'b0;
    if (rd_req) begin
      if (quiet && exp_q.size() > 0) begin
        e_pop  = 1'b1;
        m_data = exp_q.pop_back();
      end else begin
        m_nak  = 1'b1;
        m_data = '0;
      end
    end
    if (ctl_clr) begin
      e_clr = 1'b1; m_state = 0; m_trig = 1'b0; m_wrap = 1'b0; m_have = 1'b0;
    end else if (ctl_disarm && !quiet) begin
      m_state = 3;
    end else if (ctl_arm && quiet) begin
      e_clr = 1'b1; m_state = 1; m_trig = 1'b0; m_wrap = 1'b0; m_have = 1'b0;
    end else if (!quiet && clken && cpu_fetch) begin
      hit = (m_state == 1) && ctl_match_en && (cpu_pc == ctl_match_addr);
      if (hit || !m_have || cpu_pc != m_last) begin
        e_push = 1'b1;
        e_in   = cpu_pc;
        if (exp_q.size() == DEPTH) begin
          m_wrap = 1'b1;
          void'(exp_q.pop_front());
        end
        exp_q.push_back(cpu_pc);
        m_last = cpu_pc;
        m_have = 1'b1;
        if (hit) begin
          m_trig  = 1'b1;
          m_left  = PL;
          m_state = (PL == 0) ? 3 : 2;
        end else if (m_state == 2) begin
          m_left--;
          if (m_left == 0) m_state = 3;
        end
      end
    end
    if (e_clr) exp_q.delete();
  endtask

  task automatic tick();
    bit           e_push, e_pop, e_clr;
    logic [W-1:0] e_in;
    #1;
    model_step(e_push, e_pop, e_clr, e_in);
    chk("lifo_push", lifo_push, e_push);
    chk("lifo_pop", lifo_pop, e_pop);
    chk("lifo_clr", lifo_clr, e_clr);
    chk("lifo_in", lifo_in, e_in);
    @(posedge clk);
    #1;
    chk("stat_state", stat_state, m_state);
    chk("stat_trig", stat_trig, m_trig);
    chk("stat_wrap", stat_wrap, m_wrap);
    chk("rd_valid", rd_valid, m_valid);
    chk("rd_nak", rd_nak, m_nak);
    chk("rd_data", rd_data, m_data);
    rst = 1'b0; ctl_arm = 1'b0; ctl_disarm = 1'b0; ctl_clr = 1'b0;
    rd_req = 1'b0; cpu_fetch = 1'b0;
  endtask

  task automatic fetch(input logic [W-1:0] pc);
    clken = 1'b1; cpu_fetch = 1'b1; cpu_pc = pc;
    tick();
  endtask

  task automatic read_expect(input string tag, input logic [W-1:0] pc, input bit nak);
    rd_req = 1'b1;
    tick();
    chk(tag, rd_data, pc);
    chk({tag, "_nak"}, rd_nak, nak);
  endtask

  initial begin
    rst = 1'b1; clken = 1'b1; cpu_fetch = 1'b0; cpu_pc = '0;
    ctl_arm = 1'b0; ctl_disarm = 1'b0; ctl_clr = 1'b0;
    ctl_match_en = 1'b0; ctl_match_addr = '0; rd_req = 1'b0;

    // Reset state.
    tick();
    chk("rst_state", stat_state, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_trig", stat_trig, 0);
    tick();

    // Capture with a repeated PC, then drain newest-first.
    ctl_arm = 1'b1; tick();
    fetch(18'd100); fetch(18'd101); fetch(18'd101); fetch(18'd102);
    ctl_disarm = 1'b1; tick();
    chk("cap_depth", lifo_q.size(), 3);
    chk("cap_state", stat_state, 3);
    read_expect("cap_rd0", 18'd102, 1'b0);
    read_expect("cap_rd1", 18'd101, 1'b0);
    read_expect("cap_rd2", 18'd100, 1'b0);
    read_expect("cap_rd3", 18'd0, 1'b1);

    // Trigger at 200; the repeat of the trigger PC is suppressed, then PL more pushes.
    ctl_match_en = 1'b1; ctl_match_addr = 18'd200;
    ctl_arm = 1'b1; tick();
    fetch(18'd199); fetch(18'd200); fetch(18'd200);
    for (int p = 201; p <= 208; p++) fetch(W'(p));
    chk("trig_flag", stat_trig, 1);
    chk("trig_state", stat_state, 3);
    chk("trig_depth", lifo_q.size(), PL + 2);
    read_expect("trig_rd0", W'(200 + PL), 1'b0);

    // Wrap: 70 distinct PCs into a 64-deep stack.
    ctl_match_en = 1'b0;
    ctl_arm = 1'b1; tick();
    for (int p = 1; p <= 70; p++) fetch(W'(p));
    ctl_disarm = 1'b1; tick();
    chk("wrap_flag", stat_wrap, 1);
    for (int i = 0; i < DEPTH; i++) read_expect("wrap_rd", W'(70 - i), 1'b0);
    read_expect("wrap_rd_empty", 18'd0, 1'b1);

    // Read while armed is refused.
    ctl_arm = 1'b1; tick();
    rd_req = 1'b1; tick();
    chk("armrd_valid", rd_valid, 1);
    chk("armrd_nak", rd_nak, 1);
    chk("armrd_data", rd_data, 0);

    // Clear beats disarm; arm while armed does not clear the stack.
    ctl_match_en = 1'b1; ctl_match_addr = 18'd300;
    fetch(18'd300);
    chk("prio_post", stat_state, 2);
    ctl_clr = 1'b1; ctl_disarm = 1'b1; tick();
    chk("prio_idle", stat_state, 0);
    chk("prio_cleared", lifo_q.size(), 0);
    ctl_arm = 1'b1; tick();
    fetch(18'd5);
    ctl_arm = 1'b1; tick();
    chk("rearm_state", stat_state, 1);
    chk("rearm_depth", lifo_q.size(), 1);

    // Reset in POST with the counter at PL-1.
    ctl_clr = 1'b1; tick();
    ctl_match_addr = 18'd400;
    ctl_arm = 1'b1; tick();
    fetch(18'd400); fetch(18'd401);
    chk("midrst_post", stat_state, 2);
    rst = 1'b1; tick();
    chk("midrst_state", stat_state, 0);
    chk("midrst_trig", stat_trig, 0);
    chk("midrst_valid", rd_valid, 0);
    chk("midrst_depth", lifo_q.size(), 0);
    read_expect("midrst_rd", 18'd0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      clken      = ($urandom_range(0, 3) != 0);
      cpu_fetch  = ($urandom_range(0, 1) == 1);
      cpu_pc     = W'($urandom_range(0, 31));
      rd_req     = ($urandom_range(0, 3) == 0);
      ctl_arm    = ($urandom_range(0, 29) == 0);
      ctl_disarm = ($urandom_range(0, 79) == 0);
      ctl_clr    = ($urandom_range(0, 199) == 0);
      rst        = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 49) == 0) begin
        ctl_match_en   = ($urandom_range(0, 1) == 1);
        ctl_match_addr = W'($urandom_range(0, 31));
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_trace_ctl.md
Name: pc_trace_ctl

Overview:
- Capture-and-readout controller that feeds the PC-history stack (LIFO) from the CPU's instruction-fetch stream and drains it for the console.
- Pushes each new fetch PC, suppressing immediate repeats. It stops a programmable number of fetches after an address-match trigger, or on a console disarm.
- Pops entries one per console read strobe, so the most recent PC comes out first.
- Sits between the CPU fetch/PC outputs and the console register interface, and drives the push, pop and clear inputs of the LIFO.

Parameters:
- PC_WIDTH, 18, width of a KS10 virtual PC; also the LIFO WIDTH.
- POST_LEN, 16, number of fetches captured after the trigger fetch.
- CNT_WIDTH, 8, post-trigger counter width; must satisfy CNT_WIDTH >= clog2(POST_LEN+1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clken  in  1  CPU clock enable; qualifies cpu_fetch
- cpu_fetch  in  1  instruction-fetch strobe
- cpu_pc  in  PC_WIDTH  PC of the current fetch
- ctl_arm  in  1  pulse: clear the stack and start capture
- ctl_disarm  in  1  pulse: stop capture
- ctl_clr  in  1  pulse: return to idle and clear everything
- ctl_match_en  in  1  trigger enable
- ctl_match_addr  in  PC_WIDTH  trigger PC
- rd_req  in  1  console read strobe, one cycle
- rd_data  out  PC_WIDTH  popped PC
- rd_valid  out  1  one-cycle response to rd_req
- rd_nak  out  1  qualifies rd_valid: no data available
- stat_state  out  2  current FSM state
- stat_trig  out  1  sticky: trigger seen
- stat_wrap  out  1  sticky: an entry was pushed while the stack was full, so the oldest entry was lost
- lifo_clr  out  1  LIFO clear
- lifo_push  out  1  LIFO push
- lifo_pop  out  1  LIFO pop
- lifo_in  out  PC_WIDTH  LIFO write data
- lifo_out  in  PC_WIDTH  LIFO top-of-stack; combinational from the LIFO
- lifo_full  in  1  LIFO full
- lifo_empty  in  1  LIFO empty

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous, active-high.
  - The LIFO's clken is tied high by the parent. This block qualifies all pushes with clken itself.
- Reset values:
  - State IDLE.
  - All outputs 0, including rd_data and the sticky flags.
  - last_pc_vld 0.
  - lifo_clr is asserted for the reset cycle.
- States (stat_state encoding): IDLE=0, ARMED=1, POST=2, DONE=3.
- Command priority: rst > ctl_clr > ctl_disarm > ctl_arm.
- ctl_clr, in any state:
  - next state IDLE;
  - lifo_clr=1 for one cycle;
  - stat_trig, stat_wrap and last_pc_vld cleared.
- ctl_arm, accepted only in IDLE or DONE:
  - lifo_clr=1 for one cycle;
  - sticky flags and last_pc_vld cleared;
  - next state ARMED.
  - ctl_arm in ARMED or POST is ignored.
- ctl_disarm:
  - ARMED or POST -> DONE. No push occurs in that cycle.
  - In IDLE or DONE it is ignored.
- Fetch event: fe = clken & cpu_fetch, evaluated in ARMED or POST only.
- Push rule: push when fe & (!last_pc_vld | cpu_pc != last_pc).
  - lifo_push=1 and lifo_in=cpu_pc in the same cycle (zero latency).
  - last_pc <= cpu_pc and last_pc_vld <= 1.
  - If lifo_full=1 at the push, set stat_wrap. The LIFO overwrites its oldest entry.
- Trigger, in ARMED:
  - Condition: fe & ctl_match_en & cpu_pc==ctl_match_addr.
  - The trigger PC is pushed even if it repeats last_pc.
  - Set stat_trig and load cnt <= POST_LEN.
  - Next state is POST, or DONE if POST_LEN==0.
- POST:
  - Each push decrements cnt.
  - The push that brings cnt from 1 to 0 moves the FSM to DONE.
  - Suppressed repeats do not count.
- Readout:
  - rd_req is sampled in every state.
  - rd_valid is asserted exactly one cycle after rd_req.
  - If state is IDLE or DONE and lifo_empty==0:
    - lifo_pop=1 in the rd_req cycle;
    - rd_data <= lifo_out, latched in that same cycle, before the pop takes effect;
    - rd_nak=0.
  - Otherwise (stack empty, or state ARMED or POST):
    - no pop;
    - rd_data <= 0, rd_nak=1.
  - rd_req on consecutive cycles is legal; each one pops one entry.
- Push and pop are never asserted in the same cycle. Readout only pops in IDLE or DONE, and pushes happen only in ARMED or POST.
- rd_data holds its value between reads.

Decomposition:
- Shared package (ks10 trace pkg) contains:
  - the state enum TRACE_STATE_T (IDLE, ARMED, POST, DONE);
  - the typedef PC_T = logic [17:0];
  - the POST_LEN default constant.
- No sub-module inside this block. The parent instantiates the LIFO with SIZE=64, WIDTH=PC_WIDTH, clken=1.
- Roughly 200 lines of RTL: FSM, dedupe register, post counter, readout register.

Test Plan:
- Capture and readout:
  - After reset, ctl_arm. Fetch PCs 100, 101, 101, 102, then ctl_disarm.
  - Required: 3 pushes (101 pushed once); state DONE.
  - 4 rd_req pulses return 102, 101, 100 with rd_nak=0, then rd_data=0 with rd_nak=1.
- Trigger:
  - Set ctl_match_en=1, ctl_match_addr=200, POST_LEN=2. Arm and fetch 199, 200, 200, 201, 202, 203.
  - Required: pushes 199, 200, 201, 202. stat_trig=1. DONE after 202; 203 is not pushed.
- Wrap:
  - Arm, then fetch 70 distinct PCs 1..70 with no trigger, then disarm.
  - Required: stat_wrap=1. The first read returns 70. Reads stop at empty with the oldest entries lost.
- Read during capture:
  - rd_req while ARMED.
  - Required: rd_valid=1, rd_nak=1, rd_data=0 one cycle later; no lifo_pop.
- Command priority:
  - ctl_clr and ctl_disarm together in POST -> IDLE with lifo_clr=1.
  - ctl_arm while ARMED -> ignored; the stack is not cleared.
- Reset mid-capture:
  - Assert rst in POST with cnt=5.
  - Required: next cycle IDLE, all outputs 0, lifo_clr pulsed.
  - A following rd_req returns rd_nak=1.
